iic_slave_regs: RTL and testbench

//  I2C target (slave) responder, 7-bit addressing, single-byte register pointer.

---
 rtl/iic_slave_regs.sv | 235 +++++++++++++++++++++++
 tb/tb_iic_slave_regs.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_regs.sv
// I2C target with 7-bit addressing and a one-byte register pointer, oversampled on clk.
// Define IIC_SLAVE_AUTOINC_EN to advance the pointer after each write and each ACKed read byte.
`timescale 1ns/1ps

module iic_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       IIC_SCL,
  input  logic       IIC_SDA_In,
  output logic       SDA_Dir,
  output logic       SDA_Out,
  output logic [7:0] Reg_Addr,
  output logic       Reg_Wr,
  output logic [7:0] Reg_Wdata,
  output logic       Reg_Rd,
  input  logic [7:0] Reg_Rdata,
  output logic       IIC_Busy
);

`ifdef IIC_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;
  logic [7:0]             shift;
  logic [7:0]             rx_byte;
  logic [2:0]             bit_cnt;
  logic                   is_read;
  logic                   rd_acked;
  logic                   rd_load;

  // Open-drain emulation: the pad only ever pulls low.
  assign SDA_Out = 1'b0;

  // NOTE: async reset with non-blocking updates keeps every flop in one consistent step;
  // synchronizers reset to 1 (idle bus) so release from reset creates no false START.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], IIC_SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], IIC_SDA_In};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign rx_byte   = {shift[6:0], sda_s};

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      SDA_Dir   <= 1'b0;
      Reg_Addr  <= 8'h00;
      Reg_Wr    <= 1'b0;
      Reg_Wdata <= 8'h00;
      Reg_Rd    <= 1'b0;
      IIC_Busy  <= 1'b0;
      shift     <= 8'h00;
      bit_cnt   <= 3'd0;
      is_read   <= 1'b0;
      rd_acked  <= 1'b0;
      rd_load   <= 1'b0;
    end else begin
      Reg_Wr  <= 1'b0;
      Reg_Rd  <= 1'b0;
      rd_load <= Reg_Rd;

      if (AUTOINC && Reg_Wr) begin
        Reg_Addr <= Reg_Addr + 8'd1;
      end

      if (stop_det) begin
        state    <= ST_IDLE;
        SDA_Dir  <= 1'b0;
        IIC_Busy <= 1'b0;
      end else if (start_det) begin
        state    <= ST_ADDR;
        bit_cnt  <= 3'd0;
        SDA_Dir  <= 1'b0;
        IIC_Busy <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift[6:0] == SLAVE_ADDR) begin
                  state    <= ST_ADDR_ACK;
                  IIC_Busy <= 1'b1;
                  is_read  <= sda_s;
                  Reg_Rd   <= sda_s;
                end else begin
                  state <= ST_WAIT;
                end
              end
            end
          end

          // Each ACK slot: first SCL fall starts driving low, the next one ends the slot.
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!SDA_Dir) begin
                SDA_Dir <= 1'b1;
              end else begin
                bit_cnt <= 3'd0;
                if (is_read) begin
                  state   <= ST_RDATA;
                  SDA_Dir <= ~shift[7];
                end else begin
                  state   <= ST_REG;
                  SDA_Dir <= 1'b0;
                end
              end
            end
          end

          ST_REG: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                Reg_Addr <= rx_byte;
                state    <= ST_REG_ACK;
              end
            end
          end

          ST_REG_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!SDA_Dir) begin
                SDA_Dir <= 1'b1;
              end else begin
                SDA_Dir <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= ST_WDATA;
              end
            end
          end

          ST_WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                Reg_Wdata <= rx_byte;
                Reg_Wr    <= 1'b1;
                state     <= ST_WDATA_ACK;
              end
            end
          end

          // Drive low for a 0 bit, release for a 1; the shift register moves on each SCL fall.
          ST_RDATA: begin
            if (scl_fall) begin
              shift <= {shift[6:0], 1'b0};
              if (bit_cnt == 3'd7) begin
                SDA_Dir  <= 1'b0;
                rd_acked <= 1'b0;
                state    <= ST_RDATA_ACK;
              end else begin
                SDA_Dir <= ~shift[6];
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                rd_acked <= 1'b1;
                Reg_Rd   <= 1'b1;
                if (AUTOINC) begin
                  Reg_Addr <= Reg_Addr + 8'd1;
                end
              end else begin
                state <= ST_WAIT;
              end
            end else if (scl_fall && rd_acked) begin
              bit_cnt <= 3'd0;
              SDA_Dir <= ~shift[7];
              state   <= ST_RDATA;
            end
          end

          default: ;
        endcase
      end

      // Read data arrives the clk after Reg_Rd and becomes the next byte to send.
      if (rd_load) begin
        shift <= Reg_Rdata;
      end
    end
  end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed bench for iic_slave_regs: byte-level vector table plus a mid-read reset sequence.
`timescale 1ns/1ps

module tb_iic_slave_regs;

`ifdef IIC_SLAVE_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  localparam int Q = 63;  // quarter SCL period in clks (~397 kHz)

  localparam logic [7:0] P1  = AI ? 8'h11 : 8'h10;
  localparam logic [7:0] P4A = AI ? 8'h00 : 8'hFF;
  localparam logic [7:0] P4B = AI ? 8'h01 : 8'hFF;
  localparam logic [7:0] P5  = AI ? 8'h31 : 8'h30;
  localparam logic [7:0] RB2 = AI ? 8'h81 : 8'hC3;

  typedef enum logic [1:0] {OP_S, OP_P, OP_W, OP_R} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic       mack;
    logic [7:0] exp;
    logic       busy;
    logic       dir;
    logic [7:0] ptr;
    int         wr;
    int         rd;
    logic [7:0] wa;
    logic [7:0] wd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_dir;
  logic       sda_out;
  logic [7:0] reg_addr;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] mem [256];

  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] last_wa = 8'h00;
  logic [7:0] last_wd = 8'h00;
  vec_t       vt [30];

  always #5 clk = ~clk;

  assign sda_line  = m_sda & ~(sda_dir & ~sda_out);
  assign reg_rdata = mem[reg_addr];

  iic_slave_regs dut (
    .clk        (clk),
    .Rst        (rst),
    .IIC_SCL    (scl),
    .IIC_SDA_In (sda_line),
    .SDA_Dir    (sda_dir),
    .SDA_Out    (sda_out),
    .Reg_Addr   (reg_addr),
    .Reg_Wr     (reg_wr),
    .Reg_Wdata  (reg_wdata),
    .Reg_Rd     (reg_rd),
    .Reg_Rdata  (reg_rdata),
    .IIC_Busy   (busy)
  );

  always @(posedge clk) begin
    if (reg_wr) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= reg_addr;
      last_wd <= reg_wdata;
    end
    if (reg_rd) rd_cnt <= rd_cnt + 1;
    if (reg_wr && reg_rd) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; q_wait();
    scl = 1'b1;   q_wait();
    m_sda = 1'b0; q_wait();
    scl = 1'b0;   q_wait();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q_wait();
    scl = 1'b1;   q_wait();
    m_sda = 1'b1; q_wait();
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    m_sda = b; q_wait();
    scl = 1'b1; q_wait();
    s = sda_line; q_wait();
    scl = 1'b0; q_wait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(mack, s);
  endtask

  function automatic vec_t mk(op_e op, logic [7:0] data, logic mack, logic [7:0] exp,
                              logic bz, logic dir, logic [7:0] ptr, int wr, int rd,
                              logic [7:0] wa, logic [7:0] wd);
    vec_t v;
    v.op = op; v.data = data; v.mack = mack; v.exp = exp; v.busy = bz; v.dir = dir;
    v.ptr = ptr; v.wr = wr; v.rd = rd; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] rb;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h20] = 8'h5A;
    mem[8'h30] = 8'hC3;
    mem[8'h31] = 8'h81;

    //            op    data   mk  exp    bz dir ptr    wr rd wa     wd
    vt[0]  = mk(OP_S, 8'h00, 1, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
    vt[1]  = mk(OP_W, 8'h78, 1, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
    vt[2]  = mk(OP_W, 8'h10, 1, 8'h00, 1, 0, 8'h10, 0, 0, 8'h00, 8'h00);
    vt[3]  = mk(OP_W, 8'hA5, 1, 8'h00, 1, 0, P1,    1, 0, 8'h10, 8'hA5);
    vt[4]  = mk(OP_P, 8'h00, 1, 8'h00, 0, 0, P1,    1, 0, 8'h10, 8'hA5);
    vt[5]  = mk(OP_S, 8'h00, 1, 8'h00, 0, 0, P1,    1, 0, 8'h10, 8'hA5);
    vt[6]  = mk(OP_W, 8'h78, 1, 8'h00, 1, 0, P1,    1, 0, 8'h10, 8'hA5);
    vt[7]  = mk(OP_W, 8'h20, 1, 8'h00, 1, 0, 8'h20, 1, 0, 8'h10, 8'hA5);
    vt[8]  = mk(OP_S, 8'h00, 1, 8'h00, 0, 0, 8'h20, 1, 0, 8'h10, 8'hA5);
    vt[9]  = mk(OP_W, 8'h79, 1, 8'h00, 1, 1, 8'h20, 1, 1, 8'h10, 8'hA5);
    vt[10] = mk(OP_R, 8'h00, 1, 8'h5A, 1, 0, 8'h20, 1, 1, 8'h10, 8'hA5);
    vt[11] = mk(OP_P, 8'h00, 1, 8'h00, 0, 0, 8'h20, 1, 1, 8'h10, 8'hA5);
    vt[12] = mk(OP_S, 8'h00, 1, 8'h00, 0, 0, 8'h20, 1, 1, 8'h10, 8'hA5);
    vt[13] = mk(OP_W, 8'h7A, 1, 8'h01, 0, 0, 8'h20, 1, 1, 8'h10, 8'hA5);
    vt[14] = mk(OP_P, 8'h00, 1, 8'h00, 0, 0, 8'h20, 1, 1, 8'h10, 8'hA5);
    vt[15] = mk(OP_S, 8'h00, 1, 8'h00, 0, 0, 8'h20, 1, 1, 8'h10, 8'hA5);
    vt[16] = mk(OP_W, 8'h78, 1, 8'h00, 1, 0, 8'h20, 1, 1, 8'h10, 8'hA5);
    vt[17] = mk(OP_W, 8'hFF, 1, 8'h00, 1, 0, 8'hFF, 1, 1, 8'h10, 8'hA5);
    vt[18] = mk(OP_W, 8'h11, 1, 8'h00, 1, 0, P4A,   2, 1, 8'hFF, 8'h11);
    vt[19] = mk(OP_W, 8'h22, 1, 8'h00, 1, 0, P4B,   3, 1, P4A,   8'h22);
    vt[20] = mk(OP_P, 8'h00, 1, 8'h00, 0, 0, P4B,   3, 1, P4A,   8'h22);
    vt[21] = mk(OP_S, 8'h00, 1, 8'h00, 0, 0, P4B,   3, 1, P4A,   8'h22);
    vt[22] = mk(OP_W, 8'h78, 1, 8'h00, 1, 0, P4B,   3, 1, P4A,   8'h22);
    vt[23] = mk(OP_W, 8'h30, 1, 8'h00, 1, 0, 8'h30, 3, 1, P4A,   8'h22);
    vt[24] = mk(OP_S, 8'h00, 1, 8'h00, 0, 0, 8'h30, 3, 1, P4A,   8'h22);
    vt[25] = mk(OP_W, 8'h79, 1, 8'h00, 1, 0, 8'h30, 3, 2, P4A,   8'h22);
    vt[26] = mk(OP_R, 8'h00, 0, 8'hC3, 1, 0, P5,    3, 3, P4A,   8'h22);
    vt[27] = mk(OP_R, 8'h00, 1, RB2,   1, 0, P5,    3, 3, P4A,   8'h22);
    vt[28] = mk(OP_W, 8'h00, 1, 8'h01, 1, 0, P5,    3, 3, P4A,   8'h22);
    vt[29] = mk(OP_P, 8'h00, 1, 8'h00, 0, 0, P5,    3, 3, P4A,   8'h22);

    repeat (5) @(negedge clk);
    check("rst_dir",   sda_dir,   0);
    check("rst_out",   sda_out,   0);
    check("rst_addr",  reg_addr,  0);
    check("rst_wr",    reg_wr,    0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_rd",    reg_rd,    0);
    check("rst_busy",  busy,      0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      case (vt[i].op)
        OP_S: bus_start();
        OP_P: bus_stop();
        OP_W: begin
          write_byte(vt[i].data, ack);
          check($sformatf("v%0d_ack", i), ack, vt[i].exp[0]);
        end
        default: begin
          read_byte(vt[i].mack, rb);
          check($sformatf("v%0d_rbyte", i), rb, vt[i].exp);
        end
      endcase
      check($sformatf("v%0d_busy", i), busy,     vt[i].busy);
      check($sformatf("v%0d_dir", i),  sda_dir,  vt[i].dir);
      check($sformatf("v%0d_ptr", i),  reg_addr, vt[i].ptr);
      check($sformatf("v%0d_wrn", i),  wr_cnt,   vt[i].wr);
      check($sformatf("v%0d_rdn", i),  rd_cnt,   vt[i].rd);
      if (vt[i].wr > 0) begin
        check($sformatf("v%0d_wa", i), last_wa, vt[i].wa);
        check($sformatf("v%0d_wd", i), last_wd, vt[i].wd);
      end
    end

    // Reset while the target is driving a 0 data bit of a read.
    bus_start();
    write_byte(8'h78, ack);
    write_byte(8'h20, ack);
    bus_start();
    write_byte(8'h79, ack);
    check("mid_ack", ack, 0);
    check("mid_dir", sda_dir, 1);
    check("mid_rdn", rd_cnt, 4);
    rst = 1'b0;
    #1;
    check("mrst_dir",  sda_dir,  0);
    check("mrst_busy", busy,     0);
    check("mrst_addr", reg_addr, 0);
    check("mrst_line", sda_line, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    bus_start();
    write_byte(8'h78, ack);
    check("post_ack",  ack,  0);
    check("post_busy", busy, 1);
    bus_stop();
    check("post_idle", busy, 0);
    check("post_wrn",  wr_cnt, 3);
    check("post_rdn",  rd_cnt, 4);
    check("no_overlap", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
